score_counter: RTL and testbench
================================

SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_POINT, default 2: number of tick pulses per score point; legal range 1..15.
REQ-002 SHALL have parameter LEVEL_STEP, default 100: score points per speed-level increment; legal range 1..9999.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tick, input, 1 bit: one-clk_in-cycle game-time pulse from the 25 Hz divider.
REQ-006 SHALL have port start, input, 1 bit: synchronous, level-sampled start request (debounced button).
REQ-007 SHALL have port collide, input, 1 bit: synchronous collision flag from game logic.
REQ-008 SHALL have port score, output, 16 bits: four BCD digits, [15:12] thousands to [3:0] units.
REQ-009 SHALL have port hiscore, output, 16 bits: four BCD digits, same layout as score.
REQ-010 SHALL have port level, output, 3 bits: speed level 0..7.
REQ-011 SHALL have port running, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port game_over, output, 1 bit: high only in state OVER.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, RUN, OVER.
REQ-014 IDLE -> RUN when start=1; score, level and prescaler SHALL be cleared on that edge.
REQ-015 RUN -> OVER when collide=1; collide SHALL take priority over a coincident tick (no increment in that cycle).
REQ-016 OVER -> RUN when start=1, clearing score, level and prescaler; hiscore SHALL be retained.
REQ-017 In RUN, each tick=1 cycle SHALL advance a prescaler; when the prescaler reaches TICKS_PER_POINT-1 it SHALL wrap to 0 and score SHALL increment by 1 on the same edge.
REQ-018 tick SHALL be ignored in IDLE and OVER; the prescaler SHALL NOT advance there.
REQ-019 Score increment SHALL be decimal with per-digit carry (9 -> 0, carry to next digit); no binary-to-BCD conversion.
REQ-020 Score SHALL saturate at 9999: further increments leave it unchanged; level logic unaffected.
REQ-021 A separate binary counter SHALL count points since the last level step; when it reaches LEVEL_STEP it SHALL clear and level SHALL increment, saturating at 7.
REQ-022 On the RUN -> OVER edge, hiscore SHALL load score if score > hiscore (BCD compare, equal leaves unchanged); score visible in OVER is the final score, unchanged.
REQ-023 Latency: score, level and hiscore SHALL update on the rising clk_in edge that samples the qualifying tick/collide; outputs are registered, no combinational path from inputs to outputs.
REQ-024 start held high across multiple cycles in RUN SHALL have no effect; only collide leaves RUN.
REQ-025 start and collide both high in IDLE or OVER SHALL start the game; collide is ignored outside RUN.

Reset
REQ-026 reset=1 SHALL immediately force: state IDLE, score 16'h0000, hiscore 16'h0000, level 0, prescaler 0, level counter 0, running 0, game_over 0.
REQ-027 reset asserted mid-RUN SHALL abort the game and clear hiscore; no hiscore update SHALL occur on reset.
REQ-028 After reset deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-029 Reset, start pulse, 20 ticks with TICKS_PER_POINT=2 -> score 16'h0010, running=1, level 0.
REQ-030 Preload to score 0099 via ticks, two more ticks with TICKS_PER_POINT=2 -> score 16'h0100, level 1 (LEVEL_STEP=100).
REQ-031 Run until score 9999, 10 further ticks -> score stays 16'h9999, level stays 7.
REQ-032 Score 0042, tick and collide in same cycle -> score 16'h0042, game_over=1, hiscore 16'h0042; then start -> score 0, hiscore 16'h0042, running=1.
REQ-033 Second game collides at 0030 with hiscore 0042 -> hiscore stays 16'h0042; third game collides at 0042 -> hiscore unchanged.
REQ-034 reset pulse (asynchronous, mid-cycle) during RUN at score 0123 -> all outputs zero before next clk_in edge, state IDLE; ticks ignored until start.

Source files
------------

// File: rtl/score_counter.sv
// Game score keeper: IDLE/RUN/OVER control, BCD score with saturation,
// speed level derived from points scored, and a retained high score.
module score_counter #(
    parameter int TICKS_PER_POINT = 2,
    parameter int LEVEL_STEP      = 100
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        collide,
    output logic [15:0] score,
    output logic [15:0] hiscore,
    output logic [2:0]  level,
    output logic        running,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [3:0]  PRESC_MAX  = 4'(TICKS_PER_POINT - 1);
    localparam logic [13:0] LVLCNT_MAX = 14'(LEVEL_STEP - 1);
    localparam logic [15:0] SCORE_MAX  = 16'h9999;

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [15:0] hiscore_q, hiscore_d;
    logic [2:0]  level_q, level_d;
    logic [3:0]  presc_q, presc_d;
    logic [13:0] lvlcnt_q, lvlcnt_d;

    // Ripple a +1 through the four BCD digits, each wrapping 9 -> 0.
    function automatic logic [15:0] bcdInc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            score_q   <= 16'h0000;
            hiscore_q <= 16'h0000;
            level_q   <= 3'd0;
            presc_q   <= 4'd0;
            lvlcnt_q  <= 14'd0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            hiscore_q <= hiscore_d;
            level_q   <= level_d;
            presc_q   <= presc_d;
            lvlcnt_q  <= lvlcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        level_d   = level_q;
        presc_d   = presc_q;
        lvlcnt_d  = lvlcnt_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d  = RUN;
                    score_d  = 16'h0000;
                    level_d  = 3'd0;
                    presc_d  = 4'd0;
                    lvlcnt_d = 14'd0;
                end
            end
            RUN: begin
                // Collision wins over a same-cycle tick; valid BCD compares like binary.
                if (collide) begin
                    state_d = OVER;
                    if (score_q > hiscore_q) begin
                        hiscore_d = score_q;
                    end
                end else if (tick) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = 4'd0;
                        if (score_q != SCORE_MAX) begin
                            score_d = bcdInc(score_q);
                        end
                        if (lvlcnt_q == LVLCNT_MAX) begin
                            lvlcnt_d = 14'd0;
                            if (level_q != 3'd7) begin
                                level_d = level_q + 3'd1;
                            end
                        end else begin
                            lvlcnt_d = lvlcnt_q + 14'd1;
                        end
                    end else begin
                        presc_d = presc_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign score     = score_q;
    assign hiscore   = hiscore_q;
    assign level     = level_q;
    assign running   = (state_q == RUN);
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: an integer reference model feeds a
// scoreboard queue every cycle, plus targeted checks at key game moments.
module tb_score_counter;

    localparam int TPP = 2;
    localparam int LS  = 100;

    logic        clk_in;
    logic        reset;
    logic        tick;
    logic        start;
    logic        collide;
    logic [15:0] score;
    logic [15:0] hiscore;
    logic [2:0]  level;
    logic        running;
    logic        game_over;

    int vectorsApplied = 0;
    int miscompares    = 0;

    typedef struct packed {
        logic [15:0] score;
        logic [15:0] hiscore;
        logic [2:0]  level;
        logic        running;
        logic        gameOver;
    } expect_t;

    expect_t sbQueue[$];

    int mState;
    int mScore;
    int mHi;
    int mLevel;
    int mPre;
    int mLvlCnt;

    score_counter #(
        .TICKS_PER_POINT(TPP),
        .LEVEL_STEP     (LS)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .collide  (collide),
        .score    (score),
        .hiscore  (hiscore),
        .level    (level),
        .running  (running),
        .game_over(game_over)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [39:0] observed,
                               input logic [39:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState  = 0;
        mScore  = 0;
        mHi     = 0;
        mLevel  = 0;
        mPre    = 0;
        mLvlCnt = 0;
    endtask

    // States in the model: 0 idle, 1 run, 2 over.
    task automatic modelStep(input logic st, input logic co, input logic tk);
        if (mState != 1) begin
            if (st) begin
                mState  = 1;
                mScore  = 0;
                mLevel  = 0;
                mPre    = 0;
                mLvlCnt = 0;
            end
        end else if (co) begin
            mState = 2;
            if (mScore > mHi) mHi = mScore;
        end else if (tk) begin
            mPre++;
            if (mPre == TPP) begin
                mPre = 0;
                if (mScore < 9999) mScore++;
                mLvlCnt++;
                if (mLvlCnt == LS) begin
                    mLvlCnt = 0;
                    if (mLevel < 7) mLevel++;
                end
            end
        end
    endtask

    function automatic expect_t modelSnapshot();
        expect_t e;
        e.score    = toBcd(mScore);
        e.hiscore  = toBcd(mHi);
        e.level    = 3'(mLevel);
        e.running  = (mState == 1);
        e.gameOver = (mState == 2);
        return e;
    endfunction

    task automatic applyStimulus(input logic st, input logic co, input logic tk);
        expect_t e;
        expect_t got;
        @(negedge clk_in);
        start   = st;
        collide = co;
        tick    = tk;
        modelStep(st, co, tk);
        sbQueue.push_back(modelSnapshot());
        @(posedge clk_in);
        #1;
        e   = sbQueue.pop_front();
        got = {score, hiscore, level, running, game_over};
        checkOutput("sb", 40'(got), 40'(e));
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset   = 1'b1;
        tick    = 1'b0;
        start   = 1'b0;
        collide = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_score", 40'(score), 40'h0000);
        checkOutput("rst_hi", 40'(hiscore), 40'h0000);
        checkOutput("rst_level", 40'(level), 40'h0);
        checkOutput("rst_flags", 40'({running, game_over}), 40'h0);
        @(negedge clk_in);
        reset = 1'b0;

        runTicks(3);
        checkOutput("idle_tick", 40'(score), 40'h0000);

        // Game A: basic counting, level step, held start, then async reset
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTicks(20);
        checkOutput("g20_score", 40'(score), 40'h0010);
        checkOutput("g20_run", 40'(running), 40'h1);
        checkOutput("g20_level", 40'(level), 40'h0);
        runTicks(178);
        checkOutput("pre99", 40'(score), 40'h0099);
        checkOutput("pre99_lvl", 40'(level), 40'h0);
        runTicks(2);
        checkOutput("s100", 40'(score), 40'h0100);
        checkOutput("s100_lvl", 40'(level), 40'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("hold_start", 40'(score), 40'h0102);
        checkOutput("hold_run", 40'(running), 40'h1);
        runTicks(42);
        checkOutput("s123", 40'(score), 40'h0123);

        #2;
        reset = 1'b1;
        tick  = 1'b0;
        start = 1'b0;
        modelReset();
        #1;
        checkOutput("arst_score", 40'(score), 40'h0000);
        checkOutput("arst_level", 40'(level), 40'h0);
        checkOutput("arst_flags", 40'({running, game_over}), 40'h0);
        @(negedge clk_in);
        reset = 1'b0;
        runTicks(4);
        checkOutput("post_rst", 40'(score), 40'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("idle_coll", 40'({running, game_over}), 40'h0);

        // Game B: collide with coincident tick at 0042 (prescaler mid-count)
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTicks(85);
        checkOutput("s42", 40'(score), 40'h0042);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("coll_score", 40'(score), 40'h0042);
        checkOutput("coll_over", 40'(game_over), 40'h1);
        checkOutput("coll_hi", 40'(hiscore), 40'h0042);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("restart_score", 40'(score), 40'h0000);
        checkOutput("restart_hi", 40'(hiscore), 40'h0042);
        checkOutput("restart_run", 40'(running), 40'h1);

        // Game C: lower score leaves hiscore alone
        runTicks(60);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("low_hi", 40'(hiscore), 40'h0042);
        checkOutput("low_score", 40'(score), 40'h0030);

        // Game D: equal score leaves hiscore alone
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTicks(84);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("eq_hi", 40'(hiscore), 40'h0042);

        // Game E: saturation at 9999 and level 7, then new hiscore
        applyStimulus(1'b1, 1'b0, 1'b0);
        runTicks(19998);
        checkOutput("s9999", 40'(score), 40'h9999);
        runTicks(10);
        checkOutput("sat_score", 40'(score), 40'h9999);
        checkOutput("sat_level", 40'(level), 40'h7);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("max_hi", 40'(hiscore), 40'h9999);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
